// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic-light interval timer: Interval and Prog_Sel
// codes plus the timer state enum.
package traffic_pkg;

  localparam logic [1:0] INT_BASE = 2'b00;
  localparam logic [1:0] INT_EXT  = 2'b01;
  localparam logic [1:0] INT_YEL  = 2'b10;
  localparam logic [1:0] INT_SUM  = 2'b11;

  localparam logic [1:0] SEL_BASE = 2'b00;
  localparam logic [1:0] SEL_EXT  = 2'b01;
  localparam logic [1:0] SEL_YEL  = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} tmr_state_e;

endpackage

// File: rtl/traffic_param_regs.sv
// Base/extended/yellow time registers with default restore, zero clamp and the
// Interval-indexed load mux (base+extended saturates).
module traffic_param_regs
  import traffic_pkg::*;
#(
  parameter int CNT_W      = 4,
  parameter int T_BASE_DEF = 6,
  parameter int T_EXT_DEF  = 3,
  parameter int T_YEL_DEF  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_restore,
  input  logic             i_wr,
  input  logic [1:0]       i_sel,
  input  logic [CNT_W-1:0] i_val,
  input  logic [1:0]       i_interval,
  output logic [CNT_W-1:0] o_load_val
);

  logic [CNT_W-1:0] r_base, r_ext, r_yel;
  logic [CNT_W-1:0] w_wval;
  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] w_sum_sat;

  // A zero interval would never expire, so the minimum stored value is 1 s.
  assign w_wval = (i_val == '0) ? CNT_W'(1) : i_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || i_restore) begin
      r_base <= CNT_W'(T_BASE_DEF);
      r_ext  <= CNT_W'(T_EXT_DEF);
      r_yel  <= CNT_W'(T_YEL_DEF);
    end else if (i_wr) begin
      case (i_sel)
        SEL_BASE: r_base <= w_wval;
        SEL_EXT:  r_ext  <= w_wval;
        SEL_YEL:  r_yel  <= w_wval;
        default:  ;
      endcase
    end
  end

  assign w_sum     = {1'b0, r_base} + {1'b0, r_ext};
  assign w_sum_sat = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];

  always_comb begin
    o_load_val = r_base;
    case (i_interval)
      INT_BASE: o_load_val = r_base;
      INT_EXT:  o_load_val = r_ext;
      INT_YEL:  o_load_val = r_yel;
      INT_SUM:  o_load_val = w_sum_sat;
      default:  o_load_val = r_base;
    endcase
  end

endmodule

// File: rtl/traffic_interval_timer.sv
// Programmable interval timer: load on Start_Timer, count down on 1 Hz ticks,
// one-cycle Expired at zero. Define TIMER_DIVIDER_EN to derive the tick from clk.
module traffic_interval_timer
  import traffic_pkg::*;
#(
  parameter int CNT_W      = 4,
  parameter int T_BASE_DEF = 6,
  parameter int T_EXT_DEF  = 3,
`ifdef TIMER_DIVIDER_EN
  parameter int CLK_HZ     = 100,
`endif
  parameter int T_YEL_DEF  = 2
) (
  input  logic             clk,
  input  logic             Reset_n,
  input  logic             Sync_Reprogram,
  input  logic             Prog_Wr,
  input  logic [1:0]       Prog_Sel,
  input  logic [CNT_W-1:0] Prog_Val,
  input  logic             Start_Timer,
  input  logic [1:0]       Interval,
  input  logic             OneHz_En,
  output logic             Expired,
  output logic             Busy,
  output logic [CNT_W-1:0] Remaining
);

  tmr_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_exp, w_exp_nxt;
  logic [CNT_W-1:0] w_load_val;
  logic             w_tick;
  logic             w_final;

  traffic_param_regs #(
    .CNT_W(CNT_W), .T_BASE_DEF(T_BASE_DEF), .T_EXT_DEF(T_EXT_DEF), .T_YEL_DEF(T_YEL_DEF)
  ) u_params (
    .clk        (clk),
    .rst_n      (Reset_n),
    .i_restore  (Sync_Reprogram),
    .i_wr       (Prog_Wr),
    .i_sel      (Prog_Sel),
    .i_val      (Prog_Val),
    .i_interval (Interval),
    .o_load_val (w_load_val)
  );

`ifdef TIMER_DIVIDER_EN
  localparam int DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  logic [DIV_W-1:0] r_div;

  // Clearing on Start_Timer puts the first tick exactly CLK_HZ cycles after the load.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n)                                   r_div <= '0;
    else if (Sync_Reprogram || Start_Timer || w_tick) r_div <= '0;
    else                                            r_div <= r_div + 1'b1;
  end
  assign w_tick = (r_div == DIV_W'(CLK_HZ - 1));
`else
  assign w_tick = OneHz_En;
`endif

  assign w_final = (r_state == COUNT) && w_tick && (r_cnt <= CNT_W'(1));

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (Sync_Reprogram)   w_state_nxt = IDLE;
    else if (Start_Timer) w_state_nxt = COUNT;
    else if (w_final)     w_state_nxt = IDLE;
  end

  // Load beats a coincident tick, so a restart on the final tick suppresses Expired.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_exp_nxt = 1'b0;
    if (Sync_Reprogram) begin
      w_cnt_nxt = '0;
    end else if (Start_Timer) begin
      w_cnt_nxt = w_load_val;
    end else if (w_final) begin
      w_cnt_nxt = '0;
      w_exp_nxt = 1'b1;
    end else if ((r_state == COUNT) && w_tick) begin
      w_cnt_nxt = r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cnt <= '0;
      r_exp <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_exp <= w_exp_nxt;
    end
  end

  always_comb begin
    Busy      = (r_state == COUNT);
    Expired   = r_exp;
    Remaining = r_cnt;
  end

endmodule

// File: tb/tb_traffic_interval_timer.sv
// Scoreboard bench for traffic_interval_timer: stimulus queues expected
// Busy/Remaining snapshots and Expired cycles; a negedge monitor checks them.
module tb_traffic_interval_timer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sync_rp = 1'b0;
  logic       prog_wr = 1'b0;
  logic [1:0] prog_sel = 2'b00;
  logic [3:0] prog_val = 4'd0;
  logic       start = 1'b0;
  logic [1:0] interval = 2'b00;
  logic       hz = 1'b0;
  logic       expired, busy;
  logic [3:0] remaining;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic       busy;
    logic [3:0] rem;
    string      name;
  } snap_t;

  snap_t snap_q[$];
  int    exp_q[$];

  traffic_interval_timer dut (
    .clk            (clk),
    .Reset_n        (rst_n),
    .Sync_Reprogram (sync_rp),
    .Prog_Wr        (prog_wr),
    .Prog_Sel       (prog_sel),
    .Prog_Val       (prog_val),
    .Start_Timer    (start),
    .Interval       (interval),
    .OneHz_En       (hz),
    .Expired        (expired),
    .Busy           (busy),
    .Remaining      (remaining)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares whatever the scoreboard holds for the current cycle.
  always @(negedge clk) begin
    bit found;
    for (int i = snap_q.size() - 1; i >= 0; i--) begin
      if (snap_q[i].cyc == cyc) begin
        checks++;
        if (busy !== snap_q[i].busy || remaining !== snap_q[i].rem) begin
          failures++;
          $display("FAIL %s @cyc %0d: busy=%0b rem=%0d, expected busy=%0b rem=%0d",
                   snap_q[i].name, cyc, busy, remaining, snap_q[i].busy, snap_q[i].rem);
        end
        snap_q.delete(i);
      end
    end
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i] < cyc) begin
        checks++;
        failures++;
        $display("FAIL expired_missing: no pulse at cyc %0d, expected Expired=1", exp_q[i]);
        exp_q.delete(i);
      end
    end
    if (expired !== 1'b0) begin
      found = 1'b0;
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i] == cyc) begin
          found = 1'b1;
          exp_q.delete(i);
        end
      end
      checks++;
      if (!found) begin
        failures++;
        $display("FAIL expired_unexpected @cyc %0d: Expired=%0b, expected 0", cyc, expired);
      end
    end
  end

  task automatic push_snap(input int c, input logic b, input logic [3:0] r, input string nm);
    snap_t s;
    s.cyc = c; s.busy = b; s.rem = r; s.name = nm;
    snap_q.push_back(s);
  endtask

  // Holds one set of inputs across exactly one rising edge.
  task automatic drive(input logic st, input logic [1:0] iv, input logic t, input logic wr,
                       input logic [1:0] sel, input logic [3:0] val, input logic sr);
    start = st; interval = iv; hz = t; prog_wr = wr; prog_sel = sel; prog_val = val;
    sync_rp = sr;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 4'd0, 1'b0);
  endtask

  task automatic start_iv(input logic [1:0] iv, input logic [3:0] rem, input string nm);
    push_snap(cyc + 1, 1'b1, rem, nm);
    drive(1'b1, iv, 1'b0, 1'b0, 2'b00, 4'd0, 1'b0);
  endtask

  task automatic write_p(input logic [1:0] sel, input logic [3:0] val);
    drive(1'b0, 2'b00, 1'b0, 1'b1, sel, val, 1'b0);
  endtask

  // n ticks from a counter value 'from'; Expired expected when it reaches 0.
  task automatic count_down(input int from, input int n, input string nm);
    for (int k = 1; k <= n; k++) begin
      push_snap(cyc + 1, (from - k) != 0, 4'(from - k), nm);
      if (from - k == 0) exp_q.push_back(cyc + 1);
      drive(1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 4'd0, 1'b0);
      idle();
    end
  endtask

  initial begin
    @(negedge clk);
    push_snap(cyc + 1, 1'b0, 4'd0, "reset_state");
    drive(1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 4'd0, 1'b0);
    rst_n = 1'b1;
    push_snap(cyc + 1, 1'b0, 4'd0, "idle_tick");
    drive(1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 4'd0, 1'b0);

    // Default base interval: 6 ticks.
    start_iv(2'b00, 4'd6, "load_base");
    count_down(6, 6, "base_count");

    // Yellow written as 0 clamps to 1; Sel=11 changes nothing.
    write_p(2'b10, 4'd0);
    start_iv(2'b10, 4'd1, "load_yel_clamped");
    count_down(1, 1, "yel_count");
    write_p(2'b11, 4'd5);
    start_iv(2'b00, 4'd6, "sel11_base");
    start_iv(2'b01, 4'd3, "sel11_ext");
    start_iv(2'b10, 4'd1, "sel11_yel");
    count_down(1, 1, "yel_count2");

    // base+ext saturates to 15.
    write_p(2'b00, 4'd15);
    start_iv(2'b11, 4'd15, "load_sum_sat");
    count_down(15, 15, "sum_count");

    // Restart on a tick cycle: load wins, aborted interval never expires.
    start_iv(2'b01, 4'd3, "load_ext");
    count_down(3, 1, "ext_partial");
    push_snap(cyc + 1, 1'b1, 4'd3, "restart_on_tick");
    drive(1'b1, 2'b01, 1'b1, 1'b0, 2'b00, 4'd0, 1'b0);
    count_down(3, 3, "ext_after_restart");

    // Restart on the final tick suppresses Expired.
    start_iv(2'b10, 4'd1, "load_yel");
    push_snap(cyc + 1, 1'b1, 4'd1, "restart_on_final");
    drive(1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 4'd0, 1'b0);
    count_down(1, 1, "yel_after_restart");

    // Write mid-count leaves the count alone; Sync_Reprogram aborts and restores.
    start_iv(2'b00, 4'd15, "load_base15");
    count_down(15, 1, "base15_partial");
    push_snap(cyc + 1, 1'b1, 4'd14, "write_midcount");
    write_p(2'b00, 4'd9);
    push_snap(cyc + 1, 1'b0, 4'd0, "sync_abort");
    drive(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 4'd0, 1'b1);
    push_snap(cyc + 1, 1'b0, 4'd0, "sync_blocks_start");
    drive(1'b1, 2'b00, 1'b1, 1'b1, 2'b00, 4'd12, 1'b1);
    start_iv(2'b00, 4'd6, "base_restored");
    push_snap(cyc + 1, 1'b1, 4'd6, "start_write_same_cycle");
    drive(1'b1, 2'b00, 1'b0, 1'b1, 2'b00, 4'd9, 1'b0);
    start_iv(2'b00, 4'd9, "base_new_value");
    count_down(9, 1, "base9_partial");

    // Async reset between edges clears outputs immediately.
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || remaining !== 4'd0 || expired !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: busy=%0b rem=%0d exp=%0b, expected all 0",
               busy, remaining, expired);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push_snap(cyc + 1, 1'b0, 4'd0, "post_reset_tick");
      drive(1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 4'd0, 1'b0);
    end
    start_iv(2'b00, 4'd6, "post_reset_base");
    repeat (3) idle();

    checks++;
    if (exp_q.size() != 0 || snap_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d expired / %0d snapshots left, expected 0",
               exp_q.size(), snap_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
